exp_4_mux8: RTL and testbench



---
 rtl/exp_4_mux8.sv | 34 +++
 tb/tb_exp_4_mux8.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/exp_4_mux8.sv
// Registered 8-to-1 single-bit multiplexer built as a 3-level 2:1 mux tree.
// F holds I[S] as sampled on the previous rising edge and is cleared by a synchronous reset.
module exp_4_mux8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] I,
    input  logic [2:0] S,
    output logic       F
);

    logic [3:0] lvl0;
    logic [1:0] lvl1;
    logic       lvl2;

    // S[0] picks within adjacent pairs, S[1] within each half, and S[2] between the halves.
    always_comb begin
        lvl0[0] = S[0] ? I[1] : I[0];
        lvl0[1] = S[0] ? I[3] : I[2];
        lvl0[2] = S[0] ? I[5] : I[4];
        lvl0[3] = S[0] ? I[7] : I[6];
        lvl1[0] = S[1] ? lvl0[1] : lvl0[0];
        lvl1[1] = S[1] ? lvl0[3] : lvl0[2];
        lvl2    = S[2] ? lvl1[1] : lvl1[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            F <= 1'b0;
        end else begin
            F <= lvl2;
        end
    end

endmodule

// File: tb/tb_exp_4_mux8.sv
// Bench for exp_4_mux8: directed vector table, glitch and exhaustive sweeps, and a mid-stream reset.
// Inputs are driven on the falling edge, and F is sampled 1 time unit after the rising edge.
module tb_exp_4_mux8;

    typedef struct {
        logic       rst;
        logic [7:0] i;
        logic [2:0] s;
        logic       exp_f;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] I;
    logic [2:0] S;
    logic       F;

    int checks   = 0;
    int failures = 0;

    logic [0:0] exp_q[$];
    vec_t       vecs[$];

    exp_4_mux8 dut (
        .clk (clk),
        .rst (rst),
        .I   (I),
        .S   (S),
        .F   (F)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [7:0] i, input logic [2:0] s, input logic e);
        vec_t v;
        v.rst   = r;
        v.i     = i;
        v.s     = s;
        v.exp_f = e;
        return v;
    endfunction

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: F=%b expected=%b (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] i, input logic [2:0] s);
        @(negedge clk);
        rst = r;
        I   = i;
        S   = s;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] cur_i;
        logic [2:0] cur_s;
        logic [0:0] exp_v;
        logic       cur_r;
        int         n;

        rst = 1'b1;
        I   = 8'h00;
        S   = 3'd0;

        // Reset: two edges in reset with I=FF and S=5, then the first free-running edge loads I[5].
        vecs.push_back(mk(1'b1, 8'hFF, 3'd5, 1'b0));
        vecs.push_back(mk(1'b1, 8'hFF, 3'd5, 1'b0));
        vecs.push_back(mk(1'b0, 8'hFF, 3'd5, 1'b1));

        // Walking one and walking zero, each with the matching select and an adjacent one.
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(1'b0, 8'd1 << k, 3'(k), 1'b1));
            vecs.push_back(mk(1'b0, 8'd1 << k, 3'((k + 1) % 8), 1'b0));
        end
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(1'b0, ~(8'd1 << k), 3'(k), 1'b0));
            vecs.push_back(mk(1'b0, ~(8'd1 << k), 3'((k + 7) % 8), 1'b1));
        end

        // I=A5 swept over S=0..7 produces the bit sequence 1,0,1,0,0,1,0,1.
        a5 = 8'hA5;
        vecs.push_back(mk(1'b0, a5, 3'd0, 1'b1));
        vecs.push_back(mk(1'b0, a5, 3'd1, 1'b0));
        vecs.push_back(mk(1'b0, a5, 3'd2, 1'b1));
        vecs.push_back(mk(1'b0, a5, 3'd3, 1'b0));
        vecs.push_back(mk(1'b0, a5, 3'd4, 1'b0));
        vecs.push_back(mk(1'b0, a5, 3'd5, 1'b1));
        vecs.push_back(mk(1'b0, a5, 3'd6, 1'b0));
        vecs.push_back(mk(1'b0, a5, 3'd7, 1'b1));

        // Reset while I[S]=1 forces F to 0 on that edge only, and the next edge loads normally.
        vecs.push_back(mk(1'b1, 8'h80, 3'd7, 1'b0));
        vecs.push_back(mk(1'b0, 8'h80, 3'd7, 1'b1));

        for (int v = 0; v < vecs.size(); v++) begin
            drive(vecs[v].rst, vecs[v].i, vecs[v].s);
            sample();
            check($sformatf("vec%0d", v), F, vecs[v].exp_f);
        end

        // I and S toggle mid-cycle, so F must hold its registered value until the next rising edge.
        drive(1'b0, 8'h01, 3'd0);
        sample();
        check("glitch_load", F, 1'b1);
        @(negedge clk);
        I = 8'h00;
        #1;
        check("glitch_hold_i", F, 1'b1);
        S = 3'd3;
        #1;
        check("glitch_hold_s", F, 1'b1);
        sample();
        check("glitch_next", F, 1'b0);

        // Exhaustive sweep of I and S with a one-cycle reset pulse partway through.
        n = 0;
        for (int i = 0; i < 256; i++) begin
            for (int s = 0; s < 8; s++) begin
                cur_i = 8'(i);
                cur_s = 3'(s);
                cur_r = (n == 1000);
                drive(cur_r, cur_i, cur_s);
                exp_v = cur_r ? 1'b0 : cur_i[cur_s];
                exp_q.push_back(exp_v);
                sample();
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sweep_queue: expected queue empty at n=%0d", n);
                end else begin
                    exp_v = exp_q.pop_front();
                    check($sformatf("sweep_i%0d_s%0d", i, s), F, exp_v[0]);
                end
                n++;
            end
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sweep_drain: leftover=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
